// File: rtl/barrel_pkg.sv
// Shared definitions for the barrel shifter scheduler: FSM state encoding
// and default datapath geometry.
package barrel_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/barrel_core.sv
// Combinational logical barrel shifter with zero fill. One mux stage per
// shift-amount bit; stage k moves the word by 2**k positions when enabled.
module barrel_core #(
  parameter int WIDTH = barrel_pkg::WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  input  logic [SHW-1:0]   shift,
  input  logic             lr,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stg [SHW+1];

  assign stg[0] = in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    assign stg[k+1] = !shift[k] ? stg[k] :
                      (lr ? (stg[k] << AMT) : (stg[k] >> AMT));
  end

  assign out = stg[SHW];

endmodule

// File: rtl/barrel_sched.sv
// Round-robin scheduler sharing one barrel_core among N_REQ requesters.
// A granted request is latched, shifted during CALC, and held on the
// response port until the consumer takes it.
//
// state | meaning
// IDLE  | no work in flight; grant the round-robin winner if any is valid
// CALC  | operand latched; register the shifter output this cycle
// RESP  | result presented; on handshake, optionally grant the next request
module barrel_sched
  import barrel_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH),
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  input  logic [N_REQ*SHW-1:0]   req_shift,
  input  logic [N_REQ-1:0]       req_lr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic [15:0]            op_count
);

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic [WIDTH-1:0] op_data;
  logic [SHW-1:0]   op_shift;
  logic             op_lr;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] core_out;

  logic             pick_found;
  logic [IDW-1:0]   pick_id;
  logic             grant_ok;
  logic             accept;

  logic [WIDTH-1:0] data_arr  [N_REQ];
  logic [SHW-1:0]   shift_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g]  = req_data[g*WIDTH +: WIDTH];
    assign shift_arr[g] = req_shift[g*SHW +: SHW];
  end

  // Requester index 'off' positions after 'base', wrapping at N_REQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base,
                                            input int off);
    return IDW'((int'(base) + off) % N_REQ);
  endfunction

  // Round-robin pick: scan from the farthest candidate back to last_grant+1
  // so the nearest valid requester overwrites any farther one.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_valid[rr_idx(last_grant, i)]) begin
        pick_found = 1'b1;
        pick_id    = rr_idx(last_grant, i);
      end
    end
  end

  // Grants are only possible when idle or when the current result is leaving.
  always_comb begin
    grant_ok  = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
    accept    = grant_ok && pick_found;
    req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << pick_id) : '0;
  end

  barrel_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .in    (op_data),
    .shift (op_shift),
    .lr    (op_lr),
    .out   (core_out)
  );

  // Main sequencer: operand latch, result register, response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(N_REQ - 1);
      op_data    <= '0;
      op_shift   <= '0;
      op_lr      <= 1'b0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      op_count   <= 16'd0;
    end else begin
      // accept is only ever true in IDLE or in RESP with rsp_ready
      if (accept) begin
        op_data    <= data_arr[pick_id];
        op_shift   <= shift_arr[pick_id];
        op_lr      <= req_lr[pick_id];
        op_id      <= pick_id;
        last_grant <= pick_id;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_data  <= core_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + 16'd1;
            rsp_valid <= 1'b0;
            state     <= accept ? ST_CALC : ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
